multi_operand_adder_pipe: RTL



---
 rtl/multi_operand_adder_pipe.sv | 106 ++++++++++
 1 files changed

// File: rtl/multi_operand_adder_pipe.sv
// Pipelined multi-operand adder: registered binary tree summing NUM_OPS operands plus NUM_CIN carries,
// with valid/ready flow control and global stall. Optional output accumulator: MULTI_OPERAND_ADDER_ACCUM_EN.
module multi_operand_adder_pipe #(
  parameter int IN_WIDTH = 9,
  parameter int NUM_OPS = 4,
  parameter int NUM_CIN = 2,
  localparam int OUT_WIDTH = IN_WIDTH + $clog2(NUM_OPS),
  localparam int LEVELS = $clog2(NUM_OPS),
  localparam int CIN_W = (NUM_CIN > 0) ? NUM_CIN : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_OPS*IN_WIDTH-1:0] ops,
  input  logic [CIN_W-1:0]            cin,
  input  logic                        in_acc,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [OUT_WIDTH-1:0]        O,
  output logic                        out_valid,
  input  logic                        out_ready
);

  logic              en;
  logic [LEVELS:0]   valid_q;
  logic [OUT_WIDTH-1:0] tree_result;

  assign out_valid = valid_q[LEVELS];
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else if (en) valid_q <= {valid_q[LEVELS-1:0], in_valid};
  end

  // Level 0 is the input register; level l holds NUM_OPS>>l partial sums of IN_WIDTH+l bits.
  // Carries are spread one per adder in level order, so each adder's sum still fits its widened output.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N = NUM_OPS >> l;
    localparam int W = IN_WIDTH + l;
    logic [W-1:0]     sum_q [N];
    logic [CIN_W-1:0] cin_q;

    if (l == 0) begin : g_in
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < N; i++) sum_q[i] <= '0;
          cin_q <= '0;
        end else if (en) begin
          for (int i = 0; i < N; i++) sum_q[i] <= ops[i*IN_WIDTH +: IN_WIDTH];
          cin_q <= (NUM_CIN > 0) ? cin : '0;
        end
      end
    end else begin : g_add
      localparam int BASE = NUM_OPS - (NUM_OPS >> (l - 1));
      logic [N-1:0] carry;

      for (genvar i = 0; i < N; i++) begin : g_c
        if (BASE + i < NUM_CIN) begin : g_on
          assign carry[i] = g_lvl[l-1].cin_q[BASE+i];
        end else begin : g_off
          assign carry[i] = 1'b0;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < N; i++) sum_q[i] <= '0;
          cin_q <= '0;
        end else if (en) begin
          for (int i = 0; i < N; i++)
            sum_q[i] <= W'(g_lvl[l-1].sum_q[2*i]) + W'(g_lvl[l-1].sum_q[2*i+1]) + W'(carry[i]);
          cin_q <= g_lvl[l-1].cin_q;
        end
      end
    end
  end

  assign tree_result = g_lvl[LEVELS].sum_q[0];

  logic unused_cin;
  assign unused_cin = ^g_lvl[LEVELS].cin_q;

`ifdef MULTI_OPERAND_ADDER_ACCUM_EN
  logic [LEVELS:0]      acc_flag_q;
  logic [OUT_WIDTH-1:0] acc_q;

  // Accumulation is applied at the output, so consecutive accumulating samples see the latest O.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_flag_q <= '0;
      acc_q      <= '0;
    end else begin
      if (en) acc_flag_q <= {acc_flag_q[LEVELS-1:0], in_acc};
      if (out_valid && out_ready) acc_q <= O;
    end
  end

  assign O = tree_result + (acc_flag_q[LEVELS] ? acc_q : '0);
`else
  logic unused_acc;
  assign unused_acc = in_acc;
  assign O = tree_result;
`endif

endmodule
